// File: rtl/stack_ctrl.sv
// stack_ctrl -- command master for the 8x8 stack block.
//
// Accepts push/pop/clear/nop requests on a valid/ready port, drives the
// stack's cmd/data_in for exactly one clock per accepted operation and
// returns one response beat (popped byte + error flag) per request. The
// stack itself has no reset, so this block issues a clear after every reset.
//
// Optional feature macro: STACK_CTRL_CHECK_EN
//   When defined, the local occupancy count is cross-checked against the
//   stack's full/empty flags. Any disagreement sets the sticky sync_err and
//   forces rsp_err on the push/pop that completed with it.
//   When undefined, sync_err is tied low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_op[1:0], req_data[7:0] 00 nop, 01 clear, 10 push, 11 pop; push data
//   rsp_valid/rsp_ready        response handshake
//   rsp_data[7:0], rsp_err     popped byte (0 otherwise), reject/stack error
//   stk_cmd, stk_data_in       registered command/data to the stack
//   stk_data_out, stk_full, stk_empty, stk_error   stack status inputs
//   depth                      local occupancy count, 0..DEPTH
//   sync_err                   sticky flag/count mismatch
module stack_ctrl #(
  parameter int DEPTH  = 8,
  parameter int RD_LAT = 1,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [7:0]    req_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          rsp_err,
  output logic [1:0]    stk_cmd,
  output logic [7:0]    stk_data_in,
  input  logic [7:0]    stk_data_out,
  input  logic          stk_full,
  input  logic          stk_empty,
  input  logic          stk_error,
  output logic [DW-1:0] depth,
  output logic          sync_err
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_POP  = 2'b11;

  typedef enum logic [2:0] {INIT0, INIT1, IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [1:0]      op_reg;
  logic [CW-1:0]   cnt_reg;
  logic [DW-1:0]   depth_upd;
  logic            force_err;
  logic            reject;

  // Occupancy after the in-flight operation completes; a stack-reported
  // error means the operation had no effect.
  always_comb begin
    depth_upd = depth;
    if (!stk_error) begin
      case (op_reg)
        OP_PUSH: depth_upd = depth + DW'(1);
        OP_POP:  depth_upd = depth - DW'(1);
        OP_CLR:  depth_upd = '0;
        default: depth_upd = depth;
      endcase
    end
  end

  // Requests that would overflow/underflow never reach the stack.
  assign reject = ((req_op == OP_PUSH) && (depth == DW'(DEPTH))) ||
                  ((req_op == OP_POP)  && (depth == '0));

`ifdef STACK_CTRL_CHECK_EN
  function automatic logic flags_mismatch(input logic [DW-1:0] d,
                                          input logic full, input logic empty);
    return ((d == DW'(DEPTH)) != full) || ((d == '0) != empty);
  endfunction

  logic chk_cap;
  logic chk_idle;

  // At the capture edge the stack flags already reflect the operation, so
  // they are compared with the post-operation count.
  assign chk_cap   = flags_mismatch(depth_upd, stk_full, stk_empty);
  assign chk_idle  = flags_mismatch(depth, stk_full, stk_empty);
  assign force_err = ((op_reg == OP_PUSH) || (op_reg == OP_POP)) && chk_cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (((state_reg == WAIT) && (cnt_reg == '0) && chk_cap) ||
                 ((state_reg == IDLE) && chk_idle)) begin
      sync_err <= 1'b1;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = stk_full ^ stk_empty;
  assign force_err    = 1'b0;
  assign sync_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= INIT0;
      op_reg      <= OP_NOP;
      cnt_reg     <= '0;
      stk_cmd     <= OP_NOP;
      stk_data_in <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      depth       <= '0;
    end else begin
      case (state_reg)
        INIT0: begin
          stk_cmd   <= OP_CLR;   // stack contents are unknown after reset
          state_reg <= INIT1;
        end
        INIT1: begin
          stk_cmd   <= OP_NOP;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            op_reg    <= req_op;
            if ((req_op == OP_NOP) || reject) begin
              rsp_data  <= '0;
              rsp_err   <= reject;
              rsp_valid <= 1'b1;
              state_reg <= RESP;
            end else begin
              stk_cmd <= req_op;
              if (req_op == OP_PUSH) begin
                stk_data_in <= req_data;
              end
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          stk_cmd   <= OP_NOP;   // one-clock command pulse
          cnt_reg   <= CW'(RD_LAT - 1);
          state_reg <= WAIT;
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            rsp_data  <= (op_reg == OP_POP) ? stk_data_out : 8'h00;
            rsp_err   <= stk_error | force_err;
            depth     <= depth_upd;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= INIT0;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Testbench for stack_ctrl: behavioural stack model on the stack side, a
// queue-based reference model of expected responses on the request side.
module tb_stack_ctrl;

  localparam int DEPTH  = 8;
  localparam int RD_LAT = 1;

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] PUSH = 2'b10;
  localparam logic [1:0] POP  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [7:0] req_data = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [1:0] stk_cmd;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_error;
  logic [3:0] depth;
  logic       sync_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .stk_cmd(stk_cmd), .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_error(stk_error),
    .depth(depth), .sync_err(sync_err)
  );

  // Stack model: no reset, starts with garbage occupancy.
  logic [7:0] smem [DEPTH];
  int         scnt = 5;
  logic [7:0] sdout = 8'h5A;
  logic       serr = 1'b0;
  logic       force_empty = 1'b0;

  always @(posedge clk) begin
    case (stk_cmd)
      CLR: begin scnt <= 0; serr <= 1'b0; end
      PUSH: begin
        if (scnt == DEPTH) serr <= 1'b1;
        else begin smem[scnt] <= stk_data_in; scnt <= scnt + 1; serr <= 1'b0; end
      end
      POP: begin
        if (scnt == 0) serr <= 1'b1;
        else begin sdout <= smem[scnt-1]; scnt <= scnt - 1; serr <= 1'b0; end
      end
      default: ;
    endcase
  end

  assign stk_data_out = sdout;
  assign stk_error    = serr;
  assign stk_full     = (scnt == DEPTH);
  assign stk_empty    = (scnt == 0) || force_empty;

  // Command monitor: counts clocks where the stack sees a non-nop command.
  int         cmd_cnt = 0;
  logic [1:0] last_cmd = 2'b00;
  logic [7:0] last_din = 8'h00;
  always @(posedge clk) begin
    if (stk_cmd != 2'b00) begin
      cmd_cnt  <= cmd_cnt + 1;
      last_cmd <= stk_cmd;
      last_din <= stk_data_in;
    end
  end

  // Reference model: the stack contents as the requester sees them.
  logic [7:0] ref_q [$];

  // Release reset and check the initial clear pulse and ready timing.
  task automatic release_and_init(input string tag);
    int c0;
    @(negedge clk);
    rst_n = 1'b1;
    c0 = cmd_cnt;
    @(posedge clk); #1;
    checks++;
    if (stk_cmd !== CLR || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_init_edge1 stk_cmd=%0d req_ready=%0b required stk_cmd=1 req_ready=0", tag, stk_cmd, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (stk_cmd !== NOP || req_ready !== 1'b1 || depth !== 4'd0 || (cmd_cnt - c0) != 1) begin
      failures++;
      $display("FAIL %s_init_edge2 stk_cmd=%0d req_ready=%0b depth=%0d pulses=%0d required 0/1/0/1",
               tag, stk_cmd, req_ready, depth, cmd_cnt - c0);
    end
    ref_q.delete();
    $display("reset %s: released, clear pulse issued", tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (stk_cmd !== 2'b00 || stk_data_in !== 8'h00 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_data !== 8'h00 || rsp_err !== 1'b0 || depth !== 4'd0 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL %s_outputs cmd=%0d din=%h rdy=%0b rv=%0b rd=%h re=%0b depth=%0d se=%0b required all zero",
               tag, stk_cmd, stk_data_in, req_ready, rsp_valid, rsp_data, rsp_err, depth, sync_err);
    end
  endtask

  // One request/response transaction checked against the reference model.
  task automatic do_txn(input logic [1:0] op, input logic [7:0] data, input int stall, input string tag);
    logic [7:0] exp_data = 8'h00;
    logic       exp_err = 1'b0;
    int         exp_pulse = 0;
    int         exp_lat = 0;
    int         c0, n, lat;
    logic [7:0] held_data;
    logic       held_err;

    case (op)
      CLR:  begin exp_pulse = 1; exp_lat = 1 + RD_LAT; ref_q.delete(); end
      PUSH: begin
        if (ref_q.size() == DEPTH) exp_err = 1'b1;
        else begin ref_q.push_back(data); exp_pulse = 1; exp_lat = 1 + RD_LAT; end
      end
      POP: begin
        if (ref_q.size() == 0) exp_err = 1'b1;
        else begin exp_data = ref_q.pop_back(); exp_pulse = 1; exp_lat = 1 + RD_LAT; end
      end
      default: ;
    endcase

    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin
      failures++;
      $display("FAIL %s_accept_timeout req_ready=%0b required 1", tag, req_ready);
      return;
    end
    c0 = cmd_cnt;
    req_valid = 1'b1; req_op = op; req_data = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!rsp_valid || lat != exp_lat) begin
      failures++;
      $display("FAIL %s_latency rsp_valid=%0b latency=%0d required 1/%0d", tag, rsp_valid, lat, exp_lat);
      return;
    end
    held_data = rsp_data;
    held_err  = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== held_data || rsp_err !== held_err || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s_stall rv=%0b rd=%h re=%0b rdy=%0b required 1/%h/%0b/0",
                 tag, rsp_valid, rsp_data, rsp_err, req_ready, held_data, held_err);
      end
    end
    checks++;
    if (held_data !== exp_data || held_err !== exp_err) begin
      failures++;
      $display("FAIL %s_rsp data=%h err=%0b required data=%h err=%0b", tag, held_data, held_err, exp_data, exp_err);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || depth !== 4'(ref_q.size())) begin
      failures++;
      $display("FAIL %s_after rv=%0b rdy=%0b depth=%0d required 0/1/%0d", tag, rsp_valid, req_ready, depth, ref_q.size());
    end
    checks++;
    if ((cmd_cnt - c0) != exp_pulse || (exp_pulse == 1 && last_cmd !== op) ||
        (exp_pulse == 1 && op == PUSH && last_din !== data)) begin
      failures++;
      $display("FAIL %s_cmd pulses=%0d last_cmd=%0d last_din=%h required %0d/%0d/%h",
               tag, cmd_cnt - c0, last_cmd, last_din, exp_pulse, op, data);
    end
    $display("txn %s: op=%0d data=%h stall=%0d -> rsp_data=%h rsp_err=%0b depth=%0d",
             tag, op, data, stall, held_data, held_err, depth);
  endtask

  task automatic test_reset();
    #2; check_reset_outputs("reset");
    release_and_init("reset");
  endtask

  task automatic test_push_basic();
    do_txn(PUSH, 8'hA5, 0, "push_a5");
    do_txn(NOP, 8'h00, 1, "nop");
  endtask

  task automatic test_full();
    do_txn(CLR, 8'h00, 0, "clear_for_full");
    for (int i = 0; i < DEPTH; i++) do_txn(PUSH, 8'(8'h10 + i), 0, $sformatf("fill%0d", i));
    do_txn(PUSH, 8'hEE, 0, "push_overflow");
  endtask

  task automatic test_empty();
    do_txn(CLR, 8'h00, 0, "clear_for_empty");
    do_txn(POP, 8'h00, 0, "pop_underflow");
  endtask

  task automatic test_backpressure();
    do_txn(PUSH, 8'h3C, 0, "push_3c");
    do_txn(POP, 8'h00, 5, "pop_stalled");
  endtask

  task automatic test_random();
    logic [1:0] op;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      op = (r == 0) ? NOP : (r == 1) ? CLR : (r <= 6) ? PUSH : POP;
      do_txn(op, 8'($urandom_range(0, 255)), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end
    checks++;
    if (sync_err !== 1'b0) begin
      failures++;
      $display("FAIL rnd_sync_err sync_err=%0b required 0", sync_err);
    end
  endtask

  task automatic test_midop_reset();
    @(negedge clk);
    req_valid = 1'b1; req_op = PUSH; req_data = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midop_reset");
    release_and_init("midop");
    do_txn(POP, 8'h00, 0, "pop_after_reset");
  endtask

`ifdef STACK_CTRL_CHECK_EN
  task automatic test_sync_check();
    do_txn(CLR, 8'h00, 0, "clear_for_sync");
    for (int i = 0; i < 3; i++) do_txn(PUSH, 8'(i), 0, $sformatf("sync_push%0d", i));
    @(negedge clk); force_empty = 1'b1;
    repeat (2) @(negedge clk);
    force_empty = 1'b0;
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_set sync_err=%0b required 1", sync_err);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sync_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_sticky sync_err=%0b required 1", sync_err);
    end
    rst_n = 1'b0;
    #1 check_reset_outputs("sync_reset");
    release_and_init("sync");
    $display("sync check: mismatch flagged and cleared by reset");
  endtask
`endif

  initial begin
    test_reset();
    test_push_basic();
    test_full();
    test_empty();
    test_backpressure();
    test_random();
    test_midop_reset();
`ifdef STACK_CTRL_CHECK_EN
    test_sync_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
